// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the multiplexed HH:MM display scanner.
//   - active-low segment codes for digits 0-9, dash and blank (bit 7 = dp)
//   - active-low digit-select encodings, one per scan position
//   - scan position enum and small digit-extraction helpers
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] SEL_MIN1  = 4'b1110;
  localparam logic [3:0] SEL_MIN10 = 4'b1101;
  localparam logic [3:0] SEL_HR1   = 4'b1011;
  localparam logic [3:0] SEL_HR10  = 4'b0111;
  localparam logic [3:0] SEL_NONE  = 4'b1111;

  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;

  typedef enum logic [1:0] {
    DIG_MIN1  = 2'd0,
    DIG_MIN10 = 2'd1,
    DIG_HR1   = 2'd2,
    DIG_HR10  = 2'd3
  } dig_e;

  // g..a pattern of a decimal digit; anything above 9 shows blank
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = SEG_0[6:0];
      4'd1:    c = SEG_1[6:0];
      4'd2:    c = SEG_2[6:0];
      4'd3:    c = SEG_3[6:0];
      4'd4:    c = SEG_4[6:0];
      4'd5:    c = SEG_5[6:0];
      4'd6:    c = SEG_6[6:0];
      4'd7:    c = SEG_7[6:0];
      4'd8:    c = SEG_8[6:0];
      4'd9:    c = SEG_9[6:0];
      default: c = SEG_BLANK[6:0];
    endcase
    return c;
  endfunction

  // Compare ladder instead of a divider; exact for 0..99, which covers
  // every value that is not already replaced by a dash.
  function automatic logic [3:0] tens_of(input logic [7:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (v >= 8'(k * 10)) t = 4'(k);
    end
    return t;
  endfunction

  function automatic logic [3:0] ones_of(input logic [7:0] v);
    return 4'(v - 8'(tens_of(v)) * 8'd10);
  endfunction

endpackage

// File: rtl/seg_scan_hm_if.sv
// seg_scan_hm_if: time inputs and display outputs of the scanner.
//   hour[7:0], min[7:0] : binary time values (master -> slave)
//   sec_flag            : one-cycle pulse per second (master -> slave)
//   sel[3:0]            : active-low digit select (slave -> master)
//   seg[7:0]            : active-low segments, bit 7 = dp (slave -> master)
interface seg_scan_hm_if;
  logic [7:0] hour;
  logic [7:0] min;
  logic       sec_flag;
  logic [3:0] sel;
  logic [7:0] seg;

  modport master (output hour, output min, output sec_flag,
                  input  sel,  input  seg);
  modport slave  (input  hour, input  min, input  sec_flag,
                  output sel,  output seg);
endinterface

// File: rtl/seg_decode.sv
// seg_decode: one digit to g..a segment pattern (active-low).
//   i_digit[3:0] : decimal digit 0..9
//   i_blank      : force all segments off
//   i_dash       : force a dash (only g lit); wins over i_blank
//   o_seg[6:0]   : g..a
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg_code(i_digit);
    if (i_dash)       o_seg = SEG_DASH[6:0];
    else if (i_blank) o_seg = SEG_BLANK[6:0];
  end

endmodule

// File: rtl/seg_scan_hm.sv
// seg_scan_hm: 4-digit multiplexed HH:MM display scanner.
//   sys_clk    : system clock, rising edge
//   sys_rst    : synchronous active-high reset
//   bus.hour   : binary hour 0..23 (out of range shows dashes)
//   bus.min    : binary minute 0..59 (out of range shows dashes)
//   bus.sec_flag : colon toggle pulse
//   bus.sel    : registered active-low digit select
//   bus.seg    : registered active-low segments, bit 7 = colon dp
// Parameter SCAN_CNT_MAX: last value of the per-digit dwell counter.
//
// Scan position FSM:
//   state     | meaning
//   DIG_MIN1  | driving minute ones  (sel 1110)
//   DIG_MIN10 | driving minute tens  (sel 1101)
//   DIG_HR1   | driving hour ones, carries the colon dp (sel 1011)
//   DIG_HR10  | driving hour tens; leaving it starts a new frame (sel 0111)
module seg_scan_hm
  import seg_pkg::*;
#(
  parameter int SCAN_CNT_MAX = 49_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  seg_scan_hm_if.slave  bus
);

  localparam int CNT_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  logic             w_frame;

  dig_e             r_dig;
  dig_e             w_dig_nxt;

  logic [7:0]       r_snap_hour;
  logic [7:0]       r_snap_min;
  logic [7:0]       w_hour_nxt;
  logic [7:0]       w_min_nxt;
  logic             r_colon;
  logic             w_colon_nxt;

  logic [3:0]       w_digit;
  logic             w_blank;
  logic             w_dash;
  logic [6:0]       w_dec;
  logic [3:0]       w_sel_nxt;
  logic [7:0]       w_seg_nxt;

  logic [3:0]       r_sel;
  logic [7:0]       r_seg;

  assign w_tick  = (r_cnt == CNT_W'(SCAN_CNT_MAX));
  assign w_frame = w_tick && (r_dig == DIG_HR10);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)     r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CNT_W'(1);
  end

  // The output register is loaded from the post-tick view (next position,
  // next snapshot, next colon) so a frame shows the values sampled on its
  // own boundary edge and a coincident sec_flag lands in the same update.
  assign w_hour_nxt  = w_frame ? bus.hour : r_snap_hour;
  assign w_min_nxt   = w_frame ? bus.min  : r_snap_min;
  assign w_colon_nxt = r_colon ^ bus.sec_flag;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dig       <= DIG_HR10;
      r_snap_hour <= '0;
      r_snap_min  <= '0;
      r_colon     <= 1'b0;
    end else begin
      r_dig       <= w_dig_nxt;
      r_snap_hour <= w_hour_nxt;
      r_snap_min  <= w_min_nxt;
      r_colon     <= w_colon_nxt;
    end
  end

  always_comb begin
    w_dig_nxt = r_dig;
    w_sel_nxt = SEL_NONE;
    w_digit   = 4'd0;
    w_blank   = 1'b0;
    w_dash    = 1'b0;

    if (w_tick) begin
      case (r_dig)
        DIG_MIN1:  w_dig_nxt = DIG_MIN10;
        DIG_MIN10: w_dig_nxt = DIG_HR1;
        DIG_HR1:   w_dig_nxt = DIG_HR10;
        DIG_HR10:  w_dig_nxt = DIG_MIN1;
        default:   w_dig_nxt = DIG_MIN1;
      endcase
    end

    case (w_dig_nxt)
      DIG_MIN1: begin
        w_sel_nxt = SEL_MIN1;
        w_digit   = ones_of(w_min_nxt);
        w_dash    = (w_min_nxt > MIN_MAX);
      end
      DIG_MIN10: begin
        w_sel_nxt = SEL_MIN10;
        w_digit   = tens_of(w_min_nxt);
        w_dash    = (w_min_nxt > MIN_MAX);
      end
      DIG_HR1: begin
        w_sel_nxt = SEL_HR1;
        w_digit   = ones_of(w_hour_nxt);
        w_dash    = (w_hour_nxt > HOUR_MAX);
      end
      DIG_HR10: begin
        w_sel_nxt = SEL_HR10;
        w_digit   = tens_of(w_hour_nxt);
        w_dash    = (w_hour_nxt > HOUR_MAX);
        w_blank   = (w_hour_nxt < 8'd10);
      end
      default: begin
        w_sel_nxt = SEL_NONE;
      end
    endcase
  end

  seg_decode u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .i_dash  (w_dash),
    .o_seg   (w_dec)
  );

  assign w_seg_nxt = {~((w_dig_nxt == DIG_HR1) && w_colon_nxt), w_dec};

  // Outputs hold all-off after reset until the first scan tick.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sel <= SEL_NONE;
      r_seg <= SEG_BLANK;
    end else if (w_tick) begin
      r_sel <= w_sel_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.sel = r_sel;
  assign bus.seg = r_seg;

endmodule

// File: tb/tb_seg_scan_hm.sv
module tb_seg_scan_hm;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   ph;

  seg_scan_hm_if bus ();

  seg_scan_hm #(.SCAN_CNT_MAX(3)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ph counts edges since the last output update (update lands on ph==0)
  task automatic tick_clk();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic next_digit();
    do tick_clk(); while (ph != 0);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_sel, input logic [7:0] e_seg);
    check({tag, ".sel"}, {4'h0, bus.sel}, {4'h0, e_sel});
    check({tag, ".seg"}, bus.seg, e_seg);
  endtask

  task automatic frame4(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
    next_digit(); chk_out({tag, ".d0"}, 4'b1110, s0);
    next_digit(); chk_out({tag, ".d1"}, 4'b1101, s1);
    next_digit(); chk_out({tag, ".d2"}, 4'b1011, s2);
    next_digit(); chk_out({tag, ".d3"}, 4'b0111, s3);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ph = 0;
    rst = 1'b1; bus.hour = 8'd12; bus.min = 8'd34; bus.sec_flag = 1'b0;

    repeat (3) begin
      tick_clk();
      chk_out("reset_hold", 4'b1111, 8'hFF);
    end

    rst = 1'b0; ph = 0;
    repeat (3) begin
      tick_clk();
      chk_out("pre_first_update", 4'b1111, 8'hFF);
    end
    tick_clk();
    chk_out("first_update", 4'b1110, 8'h99);
    next_digit(); chk_out("f1.d1", 4'b1101, 8'hB0);
    next_digit(); chk_out("f1.d2", 4'b1011, 8'hA4);
    next_digit(); chk_out("f1.d3", 4'b0111, 8'hF9);
    frame4("repeat_12_34", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    bus.hour = 8'd5; bus.min = 8'd7;
    frame4("h5_m7", 8'hF8, 8'hC0, 8'h92, 8'hFF);

    bus.hour = 8'd25; bus.min = 8'd60;
    frame4("dash_all", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    bus.min = 8'd59;
    frame4("min59_hour_dash", 8'h90, 8'h92, 8'hBF, 8'hBF);

    bus.hour = 8'd12; bus.min = 8'd34;
    frame4("base", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    bus.sec_flag = 1'b1; tick_clk(); bus.sec_flag = 1'b0;
    frame4("colon_on", 8'h99, 8'hB0, 8'h24, 8'hF9);
    frame4("colon_on_again", 8'h99, 8'hB0, 8'h24, 8'hF9);
    bus.sec_flag = 1'b1; tick_clk(); bus.sec_flag = 1'b0;
    frame4("colon_off", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // pulse in the same cycle as scan_tick: one toggle only
    tick_clk(); tick_clk(); tick_clk();
    bus.sec_flag = 1'b1; tick_clk(); bus.sec_flag = 1'b0;
    chk_out("coinc.d0", 4'b1110, 8'h99);
    next_digit(); chk_out("coinc.d1", 4'b1101, 8'hB0);
    next_digit(); chk_out("coinc.d2", 4'b1011, 8'h24);
    next_digit(); chk_out("coinc.d3", 4'b0111, 8'hF9);
    bus.sec_flag = 1'b1; tick_clk(); bus.sec_flag = 1'b0;

    // inputs change mid-frame: current frame keeps its snapshot
    next_digit(); chk_out("midchg.d0", 4'b1110, 8'h99);
    next_digit(); chk_out("midchg.d1", 4'b1101, 8'hB0);
    bus.min = 8'd35; bus.hour = 8'd5;
    next_digit(); chk_out("midchg.d2", 4'b1011, 8'hA4);
    next_digit(); chk_out("midchg.d3", 4'b0111, 8'hF9);
    frame4("after_change", 8'h92, 8'hB0, 8'h92, 8'hFF);

    // colon on, then reset mid-frame must clear outputs and colon
    bus.hour = 8'd12; bus.min = 8'd34;
    bus.sec_flag = 1'b1; tick_clk(); bus.sec_flag = 1'b0;
    next_digit(); chk_out("prereset.d0", 4'b1110, 8'h99);
    tick_clk();
    rst = 1'b1;
    tick_clk(); chk_out("rst_mid", 4'b1111, 8'hFF);
    tick_clk(); chk_out("rst_mid_hold", 4'b1111, 8'hFF);
    bus.hour = 8'd18; bus.min = 8'd47;
    rst = 1'b0; ph = 0;
    repeat (3) begin
      tick_clk();
      chk_out("rst_release_idle", 4'b1111, 8'hFF);
    end
    tick_clk(); chk_out("restart.d0", 4'b1110, 8'hF8);
    next_digit(); chk_out("restart.d1", 4'b1101, 8'h99);
    next_digit(); chk_out("restart.d2", 4'b1011, 8'h80);
    next_digit(); chk_out("restart.d3", 4'b0111, 8'hF9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
